// File: rtl/pixel_readout.sv
// rtl/pixel_readout.sv - captures per-pixel ADC samples during the read phase into a FWFT stream FIFO
module pixel_readout #(
  parameter int pixel_count = 4,
  parameter int data_width  = 8,
  parameter int fifo_depth  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           read,
  input  logic [$clog2(pixel_count)-1:0] pixel_select,
  input  logic [data_width-1:0]          pixel_data,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [data_width-1:0]          out_data,
  output logic [$clog2(pixel_count)-1:0] out_pixel,
  output logic                           out_last,
  output logic [$clog2(fifo_depth):0]    fifo_level,
  output logic                           overflow,
  output logic                           frame_error,
  output logic [15:0]                    frame_count
);

  localparam int pw = $clog2(pixel_count);
  localparam int aw = $clog2(fifo_depth);
  localparam int ew = pw + data_width + 1;
  localparam logic [pw-1:0] last_idx = pw'(pixel_count - 1);
  localparam logic [aw:0]   full_lvl = (aw+1)'(fifo_depth);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t        state, state_next;
  logic [pw-1:0] expected, expected_next, cur_exp;
  logic          wr_req, wr_last, trunc;

  logic [ew-1:0] mem [fifo_depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [aw:0]   level;
  logic          full, pop, push;
  logic [ew-1:0] head;

  // IDLE behaves as if expected were already 0 so the first read edge can capture pixel 0
  assign cur_exp = (state == IDLE) ? '0 : expected;

  always_comb begin
    state_next    = state;
    expected_next = expected;
    wr_req        = 1'b0;
    wr_last       = 1'b0;
    trunc         = 1'b0;
    case (state)
      IDLE, CAPTURE: begin
        if (read) begin
          state_next    = CAPTURE;
          expected_next = cur_exp;
          if (pixel_select == cur_exp) begin
            wr_req        = 1'b1;
            wr_last       = (cur_exp == last_idx);
            expected_next = cur_exp + pw'(1);
            if (cur_exp == last_idx) begin
              state_next    = DONE;
              expected_next = '0;
            end
          end
        end else if (state == CAPTURE) begin
          trunc         = 1'b1;
          state_next    = IDLE;
          expected_next = '0;
        end
      end
      DONE: begin
        if (!read) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      expected <= '0;
    end else begin
      state    <= state_next;
      expected <= expected_next;
    end
  end

  assign full      = (level == full_lvl);
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // a full FIFO still accepts a write when the head leaves on the same edge
  assign push      = wr_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pixel_select, pixel_data, wr_last};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      case ({push, pop})
        2'b10:   level <= level + (aw+1)'(1);
        2'b01:   level <= level - (aw+1)'(1);
        default: level <= level;
      endcase
      if (wr_req && full && !pop) overflow <= 1'b1;
      if (trunc) frame_error <= 1'b1;
      // dropped samples still complete the frame so counting tracks the sequencer
      if (wr_req && wr_last) frame_count <= frame_count + 16'd1;
    end
  end

  assign head       = mem[rd_ptr];
  assign out_pixel  = out_valid ? head[ew-1 -: pw] : '0;
  assign out_data   = out_valid ? head[data_width:1] : '0;
  assign out_last   = out_valid ? head[0] : 1'b0;
  assign fifo_level = level;

endmodule

// File: doc/pixel_readout.md
Name: pixel_readout

Overview:
- Sits directly downstream of the sensor sequencer (erase/expose/convert/read FSM).
- During the sequencer's read phase, captures one ADC sample per pixel as pixel_select steps through the array.
- Tags each sample with its pixel index and buffers it in a FWFT FIFO.
- Presents samples as a valid/ready stream with an end-of-frame marker, plus status flags for overflow and truncated frames.

Parameters:
- pixel_count, 4, number of pixels per frame; must match the sequencer.
- data_width, 8, ADC sample width.
- fifo_depth, 8, FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- read  in  1  read-phase strobe from the sequencer.
- pixel_select  in  $clog2(pixel_count)  pixel index currently driven by the sequencer.
- pixel_data  in  data_width  ADC output for the selected pixel; valid whenever read=1.
- out_ready  in  1  downstream accepts the head entry.
- out_valid  out  1  FIFO not empty.
- out_data  out  data_width  head sample.
- out_pixel  out  $clog2(pixel_count)  head pixel index.
- out_last  out  1  head entry is the final pixel of its frame.
- fifo_level  out  $clog2(fifo_depth)+1  current occupancy, 0..fifo_depth.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- frame_error  out  1  sticky: read fell before all pixels were captured.
- frame_count  out  16  number of fully captured frames; wraps 0xFFFF->0.

Behaviour:
- Reset (reset=0, asynchronous, effective immediately, also mid-frame):
  - FIFO emptied; out_valid=0, out_data=0, out_pixel=0, out_last=0, fifo_level=0.
  - overflow=0, frame_error=0, frame_count=0.
  - FSM returns to IDLE and expected index resets to 0.
  - Sticky flags are cleared only by reset.
- Capture FSM, states IDLE, CAPTURE, DONE:
  - IDLE: read=1 -> CAPTURE with expected=0. The same edge already evaluates the capture rule below.
  - CAPTURE: on an edge with read=1 and pixel_select==expected:
    - write {pixel_select, pixel_data, last=(expected==pixel_count-1)};
    - expected++;
    - if last -> DONE and frame_count++.
  - CAPTURE: read=1 with pixel_select!=expected (held or repeated index) -> no write, no state change.
  - CAPTURE: read=0 before the last pixel is captured -> frame_error<=1, go to IDLE, expected<=0. Already-buffered entries stay in the FIFO.
  - DONE: all read activity is ignored; read=0 -> IDLE.
- Write latency: a sample captured at edge N is visible on the outputs (out_valid=1 if the FIFO was empty) after edge N. No combinational path from pixel_data to out_*.
- FIFO behaviour:
  - First-word fall-through. Pop on out_valid&&out_ready at the edge; the next entry appears after that edge.
  - Write when full with no simultaneous pop: sample dropped, overflow<=1.
  - expected still advances and frame_count still counts a completed frame, so frame timing stays intact.
  - Write and pop on the same edge while full: both succeed, level unchanged, no overflow.
  - Write and pop on the same edge while empty: write succeeds; out_valid=1 after the edge. The pop is ignored because out_valid was 0.
  - Pointers wrap modulo fifo_depth.
  - fifo_level = writes - pops, registered, updated on the same edge.
- out_ready=1 with out_valid=0 has no effect. Outputs are stable while out_valid=1 and out_ready=0.

Test Plan:
- Nominal frame: release reset; read=1, pixel_select 0,1,2,3 one per cycle, pixel_data 0x10,0x20,0x30,0x40; out_ready=1 -> stream (0x10,0),(0x20,1),(0x30,2),(0x40,3,last=1); frame_count=1; no flags.
- Held index: pixel_select held at 0 for 3 cycles with data 0x11,0x12,0x13, then 1,2,3 -> exactly 4 entries, pixel 0 data=0x11.
- Truncated frame: read falls after pixels 0,1 -> frame_error=1; 2 entries buffered; frame_count=0. The next full frame yields 4 more entries and frame_count=1.
- Overflow: out_ready=0, 3 frames (12 samples) with fifo_depth=8 -> fifo_level=8, overflow=1, frame_count=3. Draining gives frame 1 pixels 0-3 and frame 2 pixels 0-3 in order.
- Full plus simultaneous pop: FIFO full, out_ready=1 on the cycle a sample arrives -> level stays 8, overflow stays 0.
- Async reset mid-capture: reset=0 between clock edges during pixel 2 -> all outputs 0 immediately. After release, a new frame captures from pixel 0 with frame_count=1 at completion.
